vga_timing_gen: RTL and testbench

//  Pixel-timing master for the VGA path. Generates DrawX/DrawY and consumes the

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_axis_counter.sv | 34 +++
 rtl/vga_timing_gen.sv | 138 +++++++++++++
 tb/tb_vga_timing_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing for the VGA pixel-timing path.
// Holds coordinate/colour types plus helpers that locate the sync pulse on an axis.
// Pure declarations; no logic, no latency, no flow control.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int CLK_DIV_DFLT   = 2;

  localparam int H_VISIBLE_DFLT = 640;
  localparam int H_FP_DFLT      = 16;
  localparam int H_SYNC_DFLT    = 96;
  localparam int H_BP_DFLT      = 48;
  localparam int H_TOTAL_DFLT   = H_VISIBLE_DFLT + H_FP_DFLT + H_SYNC_DFLT + H_BP_DFLT;

  localparam int V_VISIBLE_DFLT = 480;
  localparam int V_FP_DFLT      = 10;
  localparam int V_SYNC_DFLT    = 2;
  localparam int V_BP_DFLT      = 33;
  localparam int V_TOTAL_DFLT   = V_VISIBLE_DFLT + V_FP_DFLT + V_SYNC_DFLT + V_BP_DFLT;

  // Largest line/frame length a 10-bit counter can represent.
  localparam int COORD_LIMIT    = 1024;

  // First count value at which the sync pulse is driven low.
  function automatic coord_t sync_first(int visible, int fp);
    return coord_t'(visible + fp);
  endfunction

  // Last count value at which the sync pulse is still low.
  function automatic coord_t sync_last(int visible, int fp, int sync);
    return coord_t'(visible + fp + sync - 1);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the raster: wrapping counter plus region decode.
// Count updates one Clk after enable; wrap/active/sync_n decode the current count combinationally.
// No backpressure; the counter advances unconditionally whenever enable is high.
module vga_axis_counter
  import vga_timing_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [10:0] total,
  input  coord_t      visible,
  input  coord_t      sync_start,
  input  coord_t      sync_end,
  output coord_t      count,
  output logic        wrap,
  output logic        active,
  output logic        sync_n
);

  // total is 11 bits so a full 1024-entry axis is expressible; count never exceeds total-1.
  assign wrap   = ({1'b0, count} == (total - 11'd1));
  assign active = (count < visible);
  assign sync_n = !((count >= sync_start) && (count <= sync_end));

  // Advance on enable, returning to zero after the last position of the axis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + 10'd1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing master: divides Clk to the pixel rate, scans DrawX/DrawY, registers pins.
// Pins (RGB, HS, VS, BLANK_N) reflect pixel (hc,vc) one pixel period later; frame_start lags wrap by 1 Clk.
// No backpressure; PixR/G/B must be valid combinationally for the current DrawX/DrawY.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DFLT,
  parameter int H_VISIBLE = H_VISIBLE_DFLT,
  parameter int H_FP      = H_FP_DFLT,
  parameter int H_SYNC    = H_SYNC_DFLT,
  parameter int H_BP      = H_BP_DFLT,
  parameter int V_VISIBLE = V_VISIBLE_DFLT,
  parameter int V_FP      = V_FP_DFLT,
  parameter int V_SYNC    = V_SYNC_DFLT,
  parameter int V_BP      = V_BP_DFLT
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] PixR,
  input  logic [7:0] PixG,
  input  logic [7:0] PixB,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       pix_en,
  output logic       frame_start,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [10:0] H_TOT = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT = 11'(V_TOTAL);

  generate
    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT || CLK_DIV < 2) begin : g_param_check
      $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 2");
    end
  endgenerate

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             h_wrap;
  logic             h_active;
  logic             h_sync_n;
  logic             v_wrap;
  logic             v_active;
  logic             v_sync_n;
  logic             visible;
  rgb_t             pin_rgb;

  assign pix_en  = (div == DIV_LAST);
  assign div_nxt = pix_en ? '0 : div + DIV_ONE;
  assign visible = h_active && v_active;

  // Pixel-rate divider; VGA_CLK is registered from the next divider value so it
  // tracks div exactly and rises mid-period, after the pin registers have settled.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div     <= '0;
      VGA_CLK <= 1'b0;
    end else begin
      div     <= div_nxt;
      VGA_CLK <= (div_nxt >= DIV_HALF);
    end
  end

  vga_axis_counter u_h_axis (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .enable     (pix_en),
    .total      (H_TOT),
    .visible    (coord_t'(H_VISIBLE)),
    .sync_start (sync_first(H_VISIBLE, H_FP)),
    .sync_end   (sync_last(H_VISIBLE, H_FP, H_SYNC)),
    .count      (DrawX),
    .wrap       (h_wrap),
    .active     (h_active),
    .sync_n     (h_sync_n)
  );

  // The vertical axis steps once per line, on the pixel that ends the line.
  vga_axis_counter u_v_axis (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .enable     (pix_en && h_wrap),
    .total      (V_TOT),
    .visible    (coord_t'(V_VISIBLE)),
    .sync_start (sync_first(V_VISIBLE, V_FP)),
    .sync_end   (sync_last(V_VISIBLE, V_FP, V_SYNC)),
    .count      (DrawY),
    .wrap       (v_wrap),
    .active     (v_active),
    .sync_n     (v_sync_n)
  );

  // One-Clk pulse following the pixel that wraps the whole frame back to (0,0).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_wrap && v_wrap;
    end
  end

  // Pin stage: capture colour and syncs for the current pixel so all DAC pins move together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pin_rgb     <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (pix_en) begin
      pin_rgb     <= visible ? rgb_t'({PixR, PixG, PixB}) : '0;
      VGA_HS      <= h_sync_n;
      VGA_VS      <= v_sync_n;
      VGA_BLANK_N <= visible;
    end
  end

  assign VGA_R      = pin_rgb.r;
  assign VGA_G      = pin_rgb.g;
  assign VGA_B      = pin_rgb.b;
  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a scaled-down raster so whole frames fit in a short run.
// Expected pins come from cycle arithmetic: pixel = t/CLK_DIV, pins show the previous pixel.
// Colour sources: random per-pixel table, constant white, or DrawX/DrawY echo.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int CD    = 3;
  localparam int HV    = 10;
  localparam int HFP   = 2;
  localparam int HSY   = 3;
  localparam int HBP   = 3;
  localparam int HT    = HV + HFP + HSY + HBP;
  localparam int VV    = 6;
  localparam int VFP   = 2;
  localparam int VSY   = 2;
  localparam int VBP   = 2;
  localparam int VT    = VV + VFP + VSY + VBP;
  localparam int FRAME = CD * HT * VT;

  localparam logic [50:0] RST_VAL = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'd0};

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] PixR, PixG, PixB;
  coord_t     DrawX, DrawY;
  logic       pix_en, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic [50:0] obs;

  int vectors = 0;
  int errors  = 0;
  int t       = 0;
  int mode    = 0;
  int pix_idx;
  logic [7:0] tab_r [HT*VT];
  logic [7:0] tab_g [HT*VT];
  logic [7:0] tab_b [HT*VT];

  always #5 Clk = ~Clk;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .PixR(PixR), .PixG(PixG), .PixB(PixB),
    .DrawX(DrawX), .DrawY(DrawY), .pix_en(pix_en), .frame_start(frame_start),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  assign obs = {DrawX, DrawY, pix_en, frame_start, VGA_CLK, VGA_HS, VGA_VS,
                VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B};

  // Colour mapper stand-in: combinational colour for the current DrawX/DrawY.
  always_comb begin
    pix_idx = int'(DrawY) * HT + int'(DrawX);
    PixR = 8'h00; PixG = 8'h00; PixB = 8'h00;
    if (mode == 1) begin
      PixR = 8'hFF; PixG = 8'hFF; PixB = 8'hFF;
    end else if (mode == 2) begin
      PixR = DrawX[7:0]; PixG = DrawY[7:0]; PixB = 8'h3C;
    end else if (pix_idx < HT*VT) begin
      PixR = tab_r[pix_idx]; PixG = tab_g[pix_idx]; PixB = tab_b[pix_idx];
    end
  end

  function automatic logic [7:0] colour(int ch, int h, int v);
    if (mode == 1) return 8'hFF;
    if (mode == 2) return (ch == 0) ? 8'(h) : (ch == 1) ? 8'(v) : 8'h3C;
    return (ch == 0) ? tab_r[v*HT+h] : (ch == 1) ? tab_g[v*HT+h] : tab_b[v*HT+h];
  endfunction

  // Expected outputs t Clk edges after reset release, from raster arithmetic.
  function automatic logic [50:0] model(int tt);
    int p = tt / CD;
    int q, h, v;
    logic vis;
    logic hs = 1'b1, vs = 1'b1, bl = 1'b0;
    logic [7:0] r = 8'h00, g = 8'h00, b = 8'h00;
    logic pe = ((tt % CD) == CD - 1);
    logic fs = (tt > 0) && ((tt % FRAME) == 0);
    logic vc = ((tt % CD) >= CD / 2);
    if (p >= 1) begin
      q   = p - 1;
      h   = q % HT;
      v   = (q / HT) % VT;
      vis = (h < HV) && (v < VV);
      hs  = !(h >= HV + HFP && h < HV + HFP + HSY);
      vs  = !(v >= VV + VFP && v < VV + VFP + VSY);
      bl  = vis;
      if (vis) begin
        r = colour(0, h, v); g = colour(1, h, v); b = colour(2, h, v);
      end
    end
    return {10'(p % HT), 10'((p / HT) % VT), pe, fs, vc, hs, vs, bl, 1'b0, r, g, b};
  endfunction

  task automatic step();
    @(posedge Clk);
    t++;
    @(negedge Clk);
  endtask

  task automatic do_reset(int m, int hold);
    @(negedge Clk);
    Reset_n = 1'b0;
    mode = m;
    for (int i = 0; i < HT*VT; i++) begin
      tab_r[i] = 8'($urandom); tab_g[i] = 8'($urandom); tab_b[i] = 8'($urandom);
    end
    repeat (hold) @(negedge Clk);
    Reset_n = 1'b1;
    t = 0;
  endtask

  task automatic test_reset();
    int v = int'($urandom_range(1, VV - 1));
    int target;
    do_reset(0, 2);
    target = ((v * HT) + HV + HFP + 1) * CD + int'($urandom_range(0, CD - 1));
    while (t < target) step();
    vectors++;
    if (obs !== model(t)) begin errors++; $display("FAIL pre_reset: got %h expected %h", obs, model(t)); end
    vectors++;
    if (VGA_HS !== 1'b0) begin errors++; $display("FAIL pre_reset_hs_low: got %b expected 0", VGA_HS); end
    #2 Reset_n = 1'b0;
    #1;
    vectors++;
    if (obs !== RST_VAL) begin errors++; $display("FAIL async_reset: got %h expected %h", obs, RST_VAL); end
    @(negedge Clk);
    vectors++;
    if (obs !== RST_VAL) begin errors++; $display("FAIL reset_held: got %h expected %h", obs, RST_VAL); end
    Reset_n = 1'b1;
    t = 0;
    vectors++;
    if (obs !== RST_VAL) begin errors++; $display("FAIL after_release: got %h expected %h", obs, RST_VAL); end
    repeat (CD) step();
    vectors++;
    if ({DrawX, DrawY} !== {10'd1, 10'd0}) begin
      errors++; $display("FAIL first_pixel_step: got x=%0d y=%0d expected x=1 y=0", DrawX, DrawY);
    end
  endtask

  task automatic test_frame_random();
    do_reset(0, 1);
    for (int i = 0; i < FRAME + CD*HT*2; i++) begin
      vectors++;
      if (obs !== model(t)) begin errors++; $display("FAIL frame_t%0d: got %h expected %h", t, obs, model(t)); end
      if (t == FRAME - 1) begin
        vectors++;
        if ({DrawX, DrawY, pix_en} !== {10'(HT-1), 10'(VT-1), 1'b1}) begin
          errors++; $display("FAIL last_pixel: got x=%0d y=%0d pe=%b", DrawX, DrawY, pix_en);
        end
      end
      if (t == FRAME) begin
        vectors++;
        if ({DrawX, DrawY, frame_start} !== {10'd0, 10'd0, 1'b1}) begin
          errors++; $display("FAIL frame_wrap: got x=%0d y=%0d fs=%b expected 0 0 1", DrawX, DrawY, frame_start);
        end
      end
      step();
    end
  endtask

  task automatic test_sync_timing();
    int n = 2*FRAME + 10;
    int t_dx = -1, last_hs = -1, last_vs = -1, last_fs = -1;
    int hs_falls = 0, vs_falls = 0, fs_cnt = 0, hs_exp = 0;
    logic p_hs = 1'b1, p_vs = 1'b1, p_fs = 1'b0;
    do_reset(0, 2);
    for (int i = 0; i < n; i++) begin
      if (t_dx < 0 && DrawX == coord_t'(HV + HFP)) t_dx = t;
      if (p_hs && !VGA_HS) begin
        vectors++;
        if (hs_falls == 0) begin
          if (t != t_dx + CD) begin errors++; $display("FAIL first_hs_fall: got t=%0d expected %0d", t, t_dx + CD); end
        end else if (t - last_hs != CD*HT) begin
          errors++; $display("FAIL hs_period: got %0d expected %0d", t - last_hs, CD*HT);
        end
        hs_falls++; last_hs = t;
      end
      if (!p_hs && VGA_HS) begin
        vectors++;
        if (t - last_hs != CD*HSY) begin errors++; $display("FAIL hs_width: got %0d expected %0d", t - last_hs, CD*HSY); end
      end
      if (p_vs && !VGA_VS) begin
        if (vs_falls > 0) begin
          vectors++;
          if (t - last_vs != FRAME) begin errors++; $display("FAIL vs_period: got %0d expected %0d", t - last_vs, FRAME); end
        end
        vs_falls++; last_vs = t;
      end
      if (!p_vs && VGA_VS) begin
        vectors++;
        if (t - last_vs != CD*HT*VSY) begin errors++; $display("FAIL vs_width: got %0d expected %0d", t - last_vs, CD*HT*VSY); end
      end
      if (p_fs) begin
        vectors++;
        if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_width: got %b expected 0", frame_start); end
      end
      if (frame_start) begin
        vectors++;
        if (t - last_fs != ((last_fs < 0) ? FRAME + 1 : FRAME)) begin
          errors++; $display("FAIL fs_period: got t=%0d last=%0d frame=%0d", t, last_fs, FRAME);
        end
        fs_cnt++; last_fs = t;
      end
      p_hs = VGA_HS; p_vs = VGA_VS; p_fs = frame_start;
      step();
    end
    for (int l = 0; (l*HT + HV + HFP + 1) * CD < n; l++) hs_exp++;
    vectors++;
    if ({hs_falls, vs_falls, fs_cnt} !== {hs_exp, 32'd2, 32'd2}) begin
      errors++; $display("FAIL sync_counts: got hs=%0d vs=%0d fs=%0d expected hs=%0d vs=2 fs=2", hs_falls, vs_falls, fs_cnt, hs_exp);
    end
  endtask

  task automatic test_const_white();
    int q, h, v, run = 0, cnt = 0, exp_n;
    logic broken = 1'b0;
    logic white;
    do_reset(1, 1);
    for (int i = 0; i <= FRAME; i++) begin
      if (t >= CD && (t % CD) == 0) begin
        q = t / CD - 1; h = q % HT; v = (q / HT) % VT;
        if (h == 0) begin run = 0; cnt = 0; broken = 1'b0; end
        white = (VGA_R == 8'hFF) && (VGA_G == 8'hFF) && (VGA_B == 8'hFF);
        vectors++;
        if (white !== VGA_BLANK_N) begin errors++; $display("FAIL blank_match x=%0d y=%0d: got blank=%b white=%b", h, v, VGA_BLANK_N, white); end
        if (white) begin cnt++; if (!broken) run++; end else broken = 1'b1;
        if (h == HT - 1) begin
          exp_n = (v < VV) ? HV : 0;
          vectors++;
          if (run != exp_n || cnt != exp_n) begin
            errors++; $display("FAIL white_line%0d: got run=%0d count=%0d expected %0d", v, run, cnt, exp_n);
          end
        end
      end
      step();
    end
  endtask

  task automatic test_drawx_latency();
    int q, ph, pv;
    logic [7:0] er;
    int skip = int'($urandom_range(0, FRAME / 2));
    do_reset(2, 1);
    repeat (skip) step();
    for (int i = 0; i < 3*HT*CD; i++) begin
      if (t >= CD && (t % CD) == 0) begin
        q = t / CD - 1; ph = q % HT; pv = (q / HT) % VT;
        er = (ph < HV && pv < VV) ? 8'(ph) : 8'h00;
        vectors++;
        if ({DrawX, VGA_R} !== {10'((t / CD) % HT), er}) begin
          errors++; $display("FAIL echo_t%0d: got x=%0d r=%h expected x=%0d r=%h", t, DrawX, VGA_R, (t / CD) % HT, er);
        end
      end
      step();
    end
  endtask

  task automatic test_random_resets();
    int n;
    for (int k = 0; k < 4; k++) begin
      do_reset(0, int'($urandom_range(1, 4)));
      n = int'($urandom_range(CD, FRAME + CD*HT));
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (obs !== model(t)) begin errors++; $display("FAIL rr%0d_t%0d: got %h expected %h", k, t, obs, model(t)); end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_random();
    test_sync_timing();
    test_const_white();
    test_drawx_latency();
    test_random_resets();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
